neuron_mac: RTL and testbench

Streaming multiply-accumulate stage that directly feeds the sigmoid activation. It computes one neuron's pre-activation sum, bias + Σ(x_i·w_i), over a variable-length input vector. All values are signed Q16.16, 32-bit. The registered result is presented on a valid/ready output that drives the sigmoid data input.

---
 rtl/neural_pkg.sv | 22 ++
 rtl/fixed_point_multiplier.sv | 27 ++
 rtl/neuron_mac.sv | 161 ++++++++++++++++
 tb/tb_neuron_mac.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pkg.sv
// Shared fixed-point types and constants for the neural datapath blocks.
// Contents:
//   fixed_t      - signed Q16.16 value
//   FRAC_BITS    - fractional bits of Q16.16
//   FIXED_*      - common Q16.16 constants (one, max, min)
//   mac_state_t  - neuron_mac control states
package neural_pkg;

   typedef logic signed [31:0] fixed_t;

   localparam int unsigned FRAC_BITS = 16;
   localparam fixed_t      FIXED_ONE = 32'h0001_0000;
   localparam fixed_t      FIXED_MAX = 32'h7FFF_FFFF;
   localparam fixed_t      FIXED_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ACCUM,
      DRAIN,
      OUT
   } mac_state_t;

endpackage

// File: rtl/fixed_point_multiplier.sv
// Combinational signed Q16.16 x Q16.16 multiplier.
// The full 64-bit Q32.32 product is shifted right by FRAC_BITS (floor) and truncated to OUT_W
// bits, so OUT_W = 32 yields Q16.16 and OUT_W = 48 yields Q32.16 with no loss of integer range.
// Ports:
//   a_i    in  32     multiplicand, Q16.16 signed
//   b_i    in  32     multiplier, Q16.16 signed
//   prod_o out OUT_W  product, signed, FRAC_BITS fractional bits
module fixed_point_multiplier
   import neural_pkg::*;
#(
   parameter int unsigned OUT_W = 48
) (
   input  logic        [31:0]      a_i,
   input  logic        [31:0]      b_i,
   output logic signed [OUT_W-1:0] prod_o
);

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] full;

   assign a_ext  = {{32{a_i[31]}}, a_i};
   assign b_ext  = {{32{b_i[31]}}, b_i};
   assign full   = a_ext * b_ext;
   assign prod_o = OUT_W'(full >>> FRAC_BITS);

endmodule

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate for one neuron: out = bias + sum(x_i * w_i), Q16.16 in/out.
// One product pipeline stage, an ACC_W-bit Q32.16 accumulator and an ACCUM/DRAIN/OUT FSM.
// Optional saturation build: define NEURON_MAC_SAT_EN to clip the result to the Q16.16 range
// and report it on out_sat; otherwise the result wraps and out_sat is 0.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input beat handshake (in_ready only in ACCUM)
//   in_data, in_weight    x_i and w_i, Q16.16 signed
//   in_bias               bias, sampled on the first beat of a vector only
//   in_last               final beat of the vector
//   out_valid/out_ready   result handshake
//   out_data              pre-activation sum, Q16.16 signed
//   out_sat               result was clipped (saturation build only)
module neuron_mac
   import neural_pkg::*;
#(
   parameter int unsigned MAX_LEN = 256,
   parameter int unsigned ACC_W   = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [31:0] in_weight,
   input  logic [31:0] in_bias,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_sat
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   mac_state_t              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] prod_q, prod_d;
   logic                    prod_vld_q, prod_vld_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    out_valid_q, out_valid_d;
   logic [31:0]             out_data_q, out_data_d;

   logic signed [ACC_W-1:0] mult_prod;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    accept;

`ifdef NEURON_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(FIXED_MAX);
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(FIXED_MIN);
   logic out_sat_q, out_sat_d;
`endif

   fixed_point_multiplier #(
      .OUT_W (ACC_W)
   ) u_mul (
      .a_i    (in_data),
      .b_i    (in_weight),
      .prod_o (mult_prod)
   );

   assign in_ready = (state_q == ACCUM);
   assign accept   = in_valid && in_ready;
   assign bias_ext = {{(ACC_W - 32){in_bias[31]}}, in_bias};

   // First beat reloads the accumulator with the bias; the pending product (always absent at
   // that point) and every later product are added one cycle after their beat.
   always_comb begin
      acc_sum = (accept && (count_q == '0)) ? bias_ext : acc_q;
      if (prod_vld_q) begin
         acc_sum = acc_sum + prod_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_sum;
      prod_d      = prod_q;
      prod_vld_d  = accept;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef NEURON_MAC_SAT_EN
      out_sat_d   = out_sat_q;
`endif
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               prod_d  = mult_prod;
               count_d = count_q + CNT_W'(1);
               if (in_last || (count_q == CNT_W'(MAX_LEN - 1))) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // acc_sum already includes the final product here.
            out_valid_d = 1'b1;
            state_d     = OUT;
`ifdef NEURON_MAC_SAT_EN
            if (acc_sum > ACC_MAX) begin
               out_data_d = FIXED_MAX;
               out_sat_d  = 1'b1;
            end else if (acc_sum < ACC_MIN) begin
               out_data_d = FIXED_MIN;
               out_sat_d  = 1'b1;
            end else begin
               out_data_d = 32'(acc_sum);
               out_sat_d  = 1'b0;
            end
`else
            out_data_d  = 32'(acc_sum);
`endif
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               count_d     = '0;
               state_d     = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef NEURON_MAC_SAT_EN
         out_sat_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         prod_vld_q  <= prod_vld_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef NEURON_MAC_SAT_EN
         out_sat_q   <= out_sat_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
`ifdef NEURON_MAC_SAT_EN
   assign out_sat   = out_sat_q;
`else
   assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (MAX_LEN = 4): table of vectors plus hand-written sequences
// for backpressure, forced last beat and reset in the middle of a vector / in OUT.
module tb_neuron_mac;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] in_weight;
   logic [31:0] in_bias;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_sat;

   int n_cmp  = 0;
   int n_fail = 0;

   neuron_mac #(
      .MAX_LEN (4),
      .ACC_W   (48)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_weight (in_weight),
      .in_bias   (in_bias),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]       bias;
      logic [2:0]        n;
      logic [3:0][31:0]  x;
      logic [3:0][31:0]  w;
      logic [31:0]       exp_data;
      logic              exp_sat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      in_weight = '0;
      in_bias   = '0;
   endtask

   task automatic drive_beat(input logic [31:0] x, input logic [31:0] w, input logic [31:0] b,
                             input logic last);
      in_valid  = 1'b1;
      in_data   = x;
      in_weight = w;
      in_bias   = b;
      in_last   = last;
   endtask

   // Sends all beats back to back, checks the DRAIN bubble, the result and the handshake.
   task automatic run_vector(input vec_t v, input string name);
      for (int i = 0; i < int'(v.n); i++) begin
         drive_beat(v.x[i], v.w[i], (i == 0) ? v.bias : 32'hDEAD_BEEF, (i == int'(v.n) - 1));
         check($sformatf("%s.in_ready[%0d]", name, i), {31'b0, in_ready}, 32'd1);
         tick();
      end
      idle_inputs();
      check({name, ".drain_valid"}, {31'b0, out_valid}, 32'd0);
      check({name, ".drain_ready"}, {31'b0, in_ready}, 32'd0);
      tick();
      check({name, ".valid"}, {31'b0, out_valid}, 32'd1);
      check({name, ".data"}, out_data, v.exp_data);
      check({name, ".sat"}, {31'b0, out_sat}, {31'b0, v.exp_sat});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, ".post_valid"}, {31'b0, out_valid}, 32'd0);
      check({name, ".post_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      // Weighted sum: 0.25 + 1.0*0.5 + 2.0*0.25 = 1.25
      vecs[0] = '0;
      vecs[0].bias = 32'h0000_4000; vecs[0].n = 3'd2;
      vecs[0].x[0] = 32'h0001_0000; vecs[0].w[0] = 32'h0000_8000;
      vecs[0].x[1] = 32'h0002_0000; vecs[0].w[1] = 32'h0000_4000;
      vecs[0].exp_data = 32'h0001_4000; vecs[0].exp_sat = 1'b0;
      // Negative product: -1.0 * 3.0 = -3.0
      vecs[1] = '0;
      vecs[1].bias = 32'h0000_0000; vecs[1].n = 3'd1;
      vecs[1].x[0] = 32'hFFFF_0000; vecs[1].w[0] = 32'h0003_0000;
      vecs[1].exp_data = 32'hFFFD_0000; vecs[1].exp_sat = 1'b0;
      // Overflow: 32767 + 2*65534 = 163835 (Q32.16 0x2_7FFB_0000)
      vecs[2] = '0;
      vecs[2].bias = 32'h7FFF_0000; vecs[2].n = 3'd2;
      vecs[2].x[0] = 32'h7FFF_0000; vecs[2].w[0] = 32'h0002_0000;
      vecs[2].x[1] = 32'h7FFF_0000; vecs[2].w[1] = 32'h0002_0000;
`ifdef NEURON_MAC_SAT_EN
      vecs[2].exp_data = 32'h7FFF_FFFF; vecs[2].exp_sat = 1'b1;
`else
      vecs[2].exp_data = 32'h7FFB_0000; vecs[2].exp_sat = 1'b0;
`endif
      // Mixed fractions: -0.5 + 1.5*2.0 + (-2.0)*0.5 + 0.25*4.0 = 2.5
      vecs[3] = '0;
      vecs[3].bias = 32'hFFFF_8000; vecs[3].n = 3'd3;
      vecs[3].x[0] = 32'h0001_8000; vecs[3].w[0] = 32'h0002_0000;
      vecs[3].x[1] = 32'hFFFE_0000; vecs[3].w[1] = 32'h0000_8000;
      vecs[3].x[2] = 32'h0000_4000; vecs[3].w[2] = 32'h0004_0000;
      vecs[3].exp_data = 32'h0002_8000; vecs[3].exp_sat = 1'b0;
      // Sub-LSB products floor: 3*0.5 LSB -> 1, -3*0.5 LSB -> -2; sum -1 LSB
      vecs[4] = '0;
      vecs[4].bias = 32'h0000_0000; vecs[4].n = 3'd2;
      vecs[4].x[0] = 32'h0000_0003; vecs[4].w[0] = 32'h0000_8000;
      vecs[4].x[1] = 32'hFFFF_FFFD; vecs[4].w[1] = 32'h0000_8000;
      vecs[4].exp_data = 32'hFFFF_FFFF; vecs[4].exp_sat = 1'b0;
      // Underflow: -32768 + (-32768)*1.0 = -65536
      vecs[5] = '0;
      vecs[5].bias = 32'h8000_0000; vecs[5].n = 3'd1;
      vecs[5].x[0] = 32'h8000_0000; vecs[5].w[0] = 32'h0001_0000;
`ifdef NEURON_MAC_SAT_EN
      vecs[5].exp_data = 32'h8000_0000; vecs[5].exp_sat = 1'b1;
`else
      vecs[5].exp_data = 32'h0000_0000; vecs[5].exp_sat = 1'b0;
`endif

      idle_inputs();
      out_ready = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("reset.in_ready", {31'b0, in_ready}, 32'd1);
      check("reset.out_valid", {31'b0, out_valid}, 32'd0);
      check("reset.out_data", out_data, 32'd0);
      check("reset.out_sat", {31'b0, out_sat}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_vector(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure: hold result for 5 cycles while a new beat waits on the input.
      for (int i = 0; i < 2; i++) begin
         drive_beat(vecs[0].x[i], vecs[0].w[i], vecs[0].bias, (i == 1));
         tick();
      end
      idle_inputs();
      tick();
      drive_beat(32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp.valid[%0d]", i), {31'b0, out_valid}, 32'd1);
         check($sformatf("bp.data[%0d]", i), out_data, 32'h0001_4000);
         check($sformatf("bp.in_ready[%0d]", i), {31'b0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp.hs_valid", {31'b0, out_valid}, 32'd0);
      check("bp.hs_in_ready", {31'b0, in_ready}, 32'd1);
      tick();  // waiting beat accepted here
      idle_inputs();
      check("bp.next_drain", {31'b0, in_ready}, 32'd0);
      tick();
      check("bp.next_valid", {31'b0, out_valid}, 32'd1);
      check("bp.next_data", out_data, 32'h0003_0000);  // 1.0 + 1.0*2.0
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Forced last: 4 beats without in_last, 5th beat starts a new vector.
      for (int i = 1; i <= 4; i++) begin
         drive_beat(32'(i) << 16, 32'h0001_0000, (i == 1) ? 32'h0001_0000 : 32'h7777_0000,
                    1'b0);
         tick();
      end
      drive_beat(32'h0002_0000, 32'h0003_0000, 32'h0000_8000, 1'b0);
      check("fl.drain_ready", {31'b0, in_ready}, 32'd0);
      check("fl.drain_valid", {31'b0, out_valid}, 32'd0);
      tick();
      check("fl.valid", {31'b0, out_valid}, 32'd1);
      check("fl.data", out_data, 32'h000B_0000);  // 1 + 1 + 2 + 3 + 4
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();  // 5th beat accepted
      drive_beat(32'h0001_0000, 32'h0001_0000, 32'h1234_0000, 1'b1);
      tick();
      idle_inputs();
      tick();
      check("fl.next_valid", {31'b0, out_valid}, 32'd1);
      check("fl.next_data", out_data, 32'h0007_8000);  // 0.5 + 6 + 1
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset mid-vector: 2 of 3 beats, then reset, then a fresh vector.
      drive_beat(32'h0001_0000, 32'h0005_0000, 32'h0010_0000, 1'b0);
      tick();
      drive_beat(32'h0002_0000, 32'h0005_0000, 32'h0010_0000, 1'b0);
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid.in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_mid.out_valid", {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_mid.no_out[%0d]", i), {31'b0, out_valid}, 32'd0);
      end
      drive_beat(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
      tick();
      idle_inputs();
      tick();
      check("rst_mid.valid", {31'b0, out_valid}, 32'd1);
      check("rst_mid.data", out_data, 32'h0001_0000);

      // Reset while a result is waiting in OUT discards it.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_out.valid", {31'b0, out_valid}, 32'd0);
      check("rst_out.data", out_data, 32'd0);
      check("rst_out.in_ready", {31'b0, in_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
